// File: rtl/vdg_pixel_serialiser_if.sv
// Fetch-side / pixel-side signal bundle for the VDG pixel serialiser.
// The master drives the byte fetch and mode inputs; the slave (the serialiser)
// returns the dot stream and status flags.
interface vdg_pixel_serialiser_if #(
  parameter int unsigned DATA_W = 8
);
  logic              PixClkEn;
  logic              Load;
  logic [DATA_W-1:0] Data;
  logic              AnG;
  logic              AnS;
  logic [2:0]        GM;
  logic              Inv;
  logic [3:0]        Row;
  logic [1:0]        Pix;
  logic [2:0]        Color;
  logic              PixValid;
  logic              LoadReq;
  logic              selAlpha;
  logic              selSemi;
  logic              Divider;
  logic              Underrun;

  modport master (
    output PixClkEn, Load, Data, AnG, AnS, GM, Inv, Row,
    input  Pix, Color, PixValid, LoadReq, selAlpha, selSemi, Divider, Underrun
  );

  modport slave (
    input  PixClkEn, Load, Data, AnG, AnS, GM, Inv, Row,
    output Pix, Color, PixValid, LoadReq, selAlpha, selSemi, Divider, Underrun
  );
endinterface

// File: rtl/vdg_pixel_serialiser.sv
// Registered VDG pixel serialiser: latches one fetched byte plus its display
// mode on Load and emits it dot by dot as alpha, SG4 semigraphics or
// 1/2 bpp graphics (optionally divided by two horizontally).
module vdg_pixel_serialiser #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = $clog2(2 * DATA_W)
) (
  input logic                  Clk,
  input logic                  Reset,
  vdg_pixel_serialiser_if.slave bus
);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t            state;
  logic [DATA_W-1:0] data_q;
  logic              ang_q;
  logic              ans_q;
  logic              inv_q;
  logic [2:0]        gm_q;
  logic [CNT_W-1:0]  idx_q;

  logic [DATA_W-1:0] sel_data;
  logic              sel_ang;
  logic              sel_ans;
  logic              sel_inv;
  logic [2:0]        sel_gm;
  logic [CNT_W-1:0]  sel_idx;
  logic [CNT_W-1:0]  last_idx;
  logic [CNT_W-1:0]  pair_idx;
  logic              sel_div;
  logic              sel_left;
  logic              sel_top;
  logic              quad_bit;
  logic [DATA_W-1:0] shifted;
  logic [1:0]        dot_pix;
  logic [2:0]        dot_color;

  // Next dot: a Load presents dot 0 of the incoming byte/mode, otherwise the
  // following dot of the byte in flight. Row is taken live for SG4.
  always_comb begin
    sel_data  = bus.Load ? bus.Data : data_q;
    sel_ang   = bus.Load ? bus.AnG  : ang_q;
    sel_ans   = bus.Load ? bus.AnS  : ans_q;
    sel_inv   = bus.Load ? bus.Inv  : inv_q;
    sel_gm    = bus.Load ? bus.GM   : gm_q;
    sel_idx   = bus.Load ? '0 : idx_q + CNT_W'(1);
    sel_div   = sel_ang & (sel_gm == 3'b000);
    last_idx  = sel_div ? CNT_W'(2 * DATA_W - 1) : CNT_W'(DATA_W - 1);
    pair_idx  = sel_div ? (sel_idx >> 2) : (sel_idx >> 1);
    sel_left  = sel_idx < CNT_W'(DATA_W / 2);
    sel_top   = bus.Row < 4'd6;
    quad_bit  = sel_top ? (sel_left ? sel_data[3] : sel_data[2])
                        : (sel_left ? sel_data[1] : sel_data[0]);
    shifted   = '0;
    dot_pix   = '0;
    dot_color = '0;
    if (!sel_ang) begin
      if (sel_ans) begin
        dot_pix   = {1'b0, quad_bit};
        dot_color = sel_data[6:4];
      end else begin
        shifted = sel_data << sel_idx;
        dot_pix = {1'b0, shifted[DATA_W-1] ^ sel_inv};
      end
    end else if (sel_gm[0]) begin
      shifted = sel_data << (sel_idx >> sel_div);
      dot_pix = {1'b0, shifted[DATA_W-1]};
    end else begin
      // 2 bpp: shift by whole pairs so the current pair lands in the top bits
      shifted = sel_data << {pair_idx, 1'b0};
      dot_pix = shifted[DATA_W-1 -: 2];
    end
  end

  // Byte/mode capture, dot sequencing and registered outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state        <= IDLE;
      data_q       <= '0;
      ang_q        <= 1'b0;
      ans_q        <= 1'b0;
      inv_q        <= 1'b0;
      gm_q         <= '0;
      idx_q        <= '0;
      bus.Pix      <= '0;
      bus.Color    <= '0;
      bus.PixValid <= 1'b0;
      bus.LoadReq  <= 1'b0;
      bus.selAlpha <= 1'b0;
      bus.selSemi  <= 1'b0;
      bus.Divider  <= 1'b0;
      bus.Underrun <= 1'b0;
    end else if (bus.PixClkEn) begin
      if (bus.Load) begin
        state        <= ACTIVE;
        data_q       <= bus.Data;
        ang_q        <= bus.AnG;
        ans_q        <= bus.AnS;
        inv_q        <= bus.Inv;
        gm_q         <= bus.GM;
        idx_q        <= '0;
        bus.Pix      <= dot_pix;
        bus.Color    <= dot_color;
        bus.PixValid <= 1'b1;
        bus.LoadReq  <= (sel_idx == last_idx);
        bus.selAlpha <= !bus.AnG & !bus.AnS;
        bus.selSemi  <= !bus.AnG & bus.AnS;
        bus.Divider  <= sel_div;
      end else if (state == ACTIVE) begin
        if (idx_q == last_idx) begin
          state        <= IDLE;
          bus.Pix      <= '0;
          bus.Color    <= '0;
          bus.PixValid <= 1'b0;
          bus.LoadReq  <= 1'b0;
          bus.Underrun <= 1'b1;
        end else begin
          idx_q        <= sel_idx;
          bus.Pix      <= dot_pix;
          bus.Color    <= dot_color;
          bus.LoadReq  <= (sel_idx == last_idx);
        end
      end
    end
  end

endmodule
